// File: rtl/mem_stage.sv
// MEM pipeline stage: synchronous 64-bit data RAM, MEM/WB register, and a
// req/ack host port that only gets the RAM when the pipeline leaves it idle.

package mem_stage_pkg;

  // Decoded MEM_MEM_CTRL bundle from EX/MEM
  typedef struct packed {
    logic rsvd;
    logic addr_sel;
    logic mem_write;
    logic mem_read;
  } mem_ctrl_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } host_state_e;

endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        MEM_WReg1,
  input  logic [DATA_W-1:0] MEM_ALUoutput,
  input  logic [DATA_W-1:0] MEM_R2out,
  input  logic [3:0]        MEM_MEM_CTRL,
  input  logic [1:0]        MEM_WB_CTRL,
  input  logic [8:0]        MEM_IMM,
  output logic [4:0]        WB_WReg1,
  output logic [DATA_W-1:0] WB_ALUoutput,
  output logic [DATA_W-1:0] WB_MEMoutput,
  output logic [1:0]        WB_WB_CTRL,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  mem_ctrl_t         w_ctrl;
  logic [ADDR_W-1:0] w_addr;
  logic              w_pipe_busy;
  logic [DATA_W-1:0] w_load_data;
  logic              w_unused;

  host_state_e       r_state;
  host_state_e       w_state_nxt;
  logic              w_grant;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [4:0]        r_wreg1;
  logic [DATA_W-1:0] r_aluout;
  logic [DATA_W-1:0] r_memout;
  logic [1:0]        r_wb_ctrl;
  logic [DATA_W-1:0] r_host_rdata;
  logic              r_host_ack;

  assign w_ctrl      = mem_ctrl_t'(MEM_MEM_CTRL);
  assign w_pipe_busy = w_ctrl.mem_read | w_ctrl.mem_write;

  // Effective address keeps only the low ADDR_W bits, so addresses wrap
  assign w_addr = w_ctrl.addr_sel ? ADDR_W'(MEM_ALUoutput) : ADDR_W'(MEM_IMM);

  // Write-first: a same-cycle store forwards its data to the load
  assign w_load_data = w_ctrl.mem_write ? MEM_R2out : r_mem[w_addr];

  // Bits intentionally dropped by address truncation and the reserved ctrl bit
  assign w_unused = ^{MEM_ALUoutput, MEM_IMM, w_ctrl};

  // Host FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Host FSM next state; pipeline memory ops always win the RAM
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (host_req && !w_pipe_busy) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // RAM write port; contents survive reset but no write lands while in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      if (w_ctrl.mem_write) begin
        r_mem[w_addr] <= MEM_R2out;
      end else if (w_grant && host_we) begin
        r_mem[host_addr] <= host_wdata;
      end
    end
  end

  // MEM/WB register, including load data
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wreg1   <= '0;
      r_aluout  <= '0;
      r_memout  <= '0;
      r_wb_ctrl <= '0;
    end else begin
      r_wreg1   <= MEM_WReg1;
      r_aluout  <= MEM_ALUoutput;
      r_memout  <= w_ctrl.mem_read ? w_load_data : '0;
      r_wb_ctrl <= MEM_WB_CTRL;
    end
  end

  // Host response: ack pulses the cycle after grant, rdata holds until next grant
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      r_host_ack <= w_grant;
      if (w_grant) begin
        r_host_rdata <= host_we ? host_wdata : r_mem[host_addr];
      end
    end
  end

  assign WB_WReg1     = r_wreg1;
  assign WB_ALUoutput = r_aluout;
  assign WB_MEMoutput = r_memout;
  assign WB_WB_CTRL   = r_wb_ctrl;
  assign host_rdata   = r_host_rdata;
  assign host_ack     = r_host_ack;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, store/load, addressing, host arbitration,
// handshake pacing and reset during host access.

module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [4:0]  MEM_WReg1;
  logic [63:0] MEM_ALUoutput;
  logic [63:0] MEM_R2out;
  logic [3:0]  MEM_MEM_CTRL;
  logic [1:0]  MEM_WB_CTRL;
  logic [8:0]  MEM_IMM;
  logic [4:0]  WB_WReg1;
  logic [63:0] WB_ALUoutput;
  logic [63:0] WB_MEMoutput;
  logic [1:0]  WB_WB_CTRL;
  logic        host_req;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [63:0] host_wdata;
  logic [63:0] host_rdata;
  logic        host_ack;

  int checks   = 0;
  int failures = 0;
  int ack_cnt;

  mem_stage #(.ADDR_W(8), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .MEM_WReg1(MEM_WReg1), .MEM_ALUoutput(MEM_ALUoutput), .MEM_R2out(MEM_R2out),
    .MEM_MEM_CTRL(MEM_MEM_CTRL), .MEM_WB_CTRL(MEM_WB_CTRL), .MEM_IMM(MEM_IMM),
    .WB_WReg1(WB_WReg1), .WB_ALUoutput(WB_ALUoutput), .WB_MEMoutput(WB_MEMoutput),
    .WB_WB_CTRL(WB_WB_CTRL),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pipe(input logic [3:0] ctrl, input logic [63:0] alu, input logic [8:0] imm,
                      input logic [63:0] r2, input logic [4:0] wreg, input logic [1:0] wbc);
    MEM_MEM_CTRL  = ctrl;
    MEM_ALUoutput = alu;
    MEM_IMM       = imm;
    MEM_R2out     = r2;
    MEM_WReg1     = wreg;
    MEM_WB_CTRL   = wbc;
  endtask

  task automatic host(input logic req, input logic we, input logic [7:0] addr,
                      input logic [63:0] wdata);
    host_req   = req;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
  endtask

  initial begin
    reset = 1'b0;
    pipe(4'b0000, 64'h0, 9'h0, 64'h0, 5'd0, 2'd0);
    host(1'b0, 1'b0, 8'h0, 64'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Preload RAM[5] = 0xAA through the host port
    host(1'b1, 1'b1, 8'h05, 64'hAA);
    tick();
    chk("preload_ack", 64'(host_ack), 64'd1);
    chk("preload_rdata", host_rdata, 64'hAA);
    host(1'b0, 1'b0, 8'h00, 64'h0);
    tick();
    chk("preload_ack_drop", 64'(host_ack), 64'd0);

    // Reset with nonzero inputs, including a store to word 5 that must be blocked
    reset = 1'b0;
    pipe(4'b0110, 64'h5, 9'h0, 64'h55, 5'd7, 2'd3);
    tick();
    tick();
    chk("rst_wreg1", 64'(WB_WReg1), 64'd0);
    chk("rst_aluout", WB_ALUoutput, 64'd0);
    chk("rst_memout", WB_MEMoutput, 64'd0);
    chk("rst_wbctrl", 64'(WB_WB_CTRL), 64'd0);
    chk("rst_ack", 64'(host_ack), 64'd0);
    chk("rst_rdata", host_rdata, 64'd0);
    reset = 1'b1;
    pipe(4'b0000, 64'h0, 9'h0, 64'h0, 5'd0, 2'd0);
    host(1'b1, 1'b0, 8'h05, 64'h0);
    tick();
    chk("ram_kept_ack", 64'(host_ack), 64'd1);
    chk("ram_kept_rdata", host_rdata, 64'hAA);
    host(1'b0, 1'b0, 8'h00, 64'h0);
    tick();

    // Store then load at 0x10
    pipe(4'b0110, 64'h10, 9'h0, 64'h1122334455667788, 5'd3, 2'd1);
    tick();
    chk("store_memout", WB_MEMoutput, 64'd0);
    chk("store_aluout", WB_ALUoutput, 64'h10);
    pipe(4'b0101, 64'h10, 9'h0, 64'h0, 5'd9, 2'd2);
    tick();
    chk("load_memout", WB_MEMoutput, 64'h1122334455667788);
    chk("load_wreg1", 64'(WB_WReg1), 64'd9);
    chk("load_wbctrl", 64'(WB_WB_CTRL), 64'd2);

    // Address wrap: IMM 0x105 and ALU 0xFFFF_0000_0000_0105 both hit word 5
    pipe(4'b0010, 64'h0, 9'h105, 64'hBEEF, 5'd0, 2'd0);
    tick();
    pipe(4'b0101, 64'hFFFF_0000_0000_0105, 9'h0, 64'h0, 5'd1, 2'd0);
    tick();
    chk("wrap_load", WB_MEMoutput, 64'hBEEF);

    // Write-first when read and write collide
    pipe(4'b0111, 64'h20, 9'h0, 64'hCAFE, 5'd2, 2'd0);
    tick();
    chk("write_first", WB_MEMoutput, 64'hCAFE);

    // Host read of word 5 blocked by three pipeline loads
    host(1'b1, 1'b0, 8'h05, 64'h0);
    pipe(4'b0101, 64'h10, 9'h0, 64'h0, 5'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("arb_blocked_%0d", i), 64'(host_ack), 64'd0);
    end
    pipe(4'b0000, 64'h0, 9'h0, 64'h0, 5'd0, 2'd0);
    tick();
    chk("arb_ack", 64'(host_ack), 64'd1);
    chk("arb_rdata", host_rdata, 64'hBEEF);
    host(1'b0, 1'b0, 8'h00, 64'h0);
    tick();
    chk("arb_ack_drop", 64'(host_ack), 64'd0);
    chk("arb_rdata_hold", host_rdata, 64'hBEEF);

    // Pacing: req held 6 cycles -> ack on every other cycle
    ack_cnt = 0;
    host(1'b1, 1'b0, 8'h10, 64'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("pace_%0d", i), 64'(host_ack), (i % 2 == 0) ? 64'd1 : 64'd0);
      if (host_ack) ack_cnt++;
    end
    chk("pace_count", 64'(ack_cnt), 64'd3);
    chk("pace_rdata", host_rdata, 64'h1122334455667788);

    // Host write visible to a pipeline load in the ACK cycle
    host(1'b1, 1'b1, 8'h30, 64'h77);
    tick();
    chk("hw_ack", 64'(host_ack), 64'd1);
    host(1'b0, 1'b0, 8'h00, 64'h0);
    pipe(4'b0101, 64'h30, 9'h0, 64'h0, 5'd0, 2'd0);
    tick();
    chk("hw_then_load", WB_MEMoutput, 64'h77);
    pipe(4'b0000, 64'h0, 9'h0, 64'h0, 5'd0, 2'd0);

    // Prior value of word 7, then a write of 0xDEAD granted during reset
    host(1'b1, 1'b1, 8'h07, 64'h1234);
    tick();
    host(1'b0, 1'b0, 8'h00, 64'h0);
    tick();
    host(1'b1, 1'b1, 8'h07, 64'hDEAD);
    reset = 1'b0;
    tick();
    chk("rst_grant_ack", 64'(host_ack), 64'd0);
    reset = 1'b1;
    host(1'b0, 1'b0, 8'h00, 64'h0);
    tick();
    chk("rst_grant_no_late_ack", 64'(host_ack), 64'd0);
    host(1'b1, 1'b0, 8'h07, 64'h0);
    tick();
    chk("rst_grant_read_ack", 64'(host_ack), 64'd1);
    chk("rst_grant_read_data", host_rdata, 64'h1234);

    // Reset while in ACK clears the pulse
    host(1'b0, 1'b0, 8'h00, 64'h0);
    tick();
    host(1'b1, 1'b0, 8'h07, 64'h0);
    tick();
    chk("ack_before_rst", 64'(host_ack), 64'd1);
    reset = 1'b0;
    host(1'b0, 1'b0, 8'h00, 64'h0);
    tick();
    chk("ack_rst_cleared", 64'(host_ack), 64'd0);
    chk("ack_rst_rdata", host_rdata, 64'd0);
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
